// File: rtl/axi4_lite_req_arbiter_if.sv
// Bundle of requester-side and master-side command signals around the shared
// AXI4-Lite command port; modport slave is the arbiter view, master is the environment view.
interface axi4_lite_req_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_write;
  logic [NUM_REQ*32-1:0] req_addr;
  logic [NUM_REQ*32-1:0] req_wdata;
  logic [NUM_REQ*4-1:0]  req_wstrb;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [31:0]           rsp_rdata;
  logic [1:0]            rsp_resp;
  logic                  m_write_en;
  logic                  m_read_en;
  logic [31:0]           m_addr;
  logic [31:0]           m_wdata;
  logic [3:0]            m_wstrb;
  logic [31:0]           m_read_data;
  logic [1:0]            m_write_resp;
  logic [1:0]            m_read_resp;
  logic                  m_write_done;
  logic                  m_read_done;
  logic                  busy;
  logic [1:0]            dbg_state;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
    input  m_read_data, m_write_resp, m_read_resp, m_write_done, m_read_done,
    output req_ready, rsp_valid, rsp_rdata, rsp_resp,
    output m_write_en, m_read_en, m_addr, m_wdata, m_wstrb, busy, dbg_state
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb,
    output m_read_data, m_write_resp, m_read_resp, m_write_done, m_read_done,
    input  req_ready, rsp_valid, rsp_rdata, rsp_resp,
    input  m_write_en, m_read_en, m_addr, m_wdata, m_wstrb, busy, dbg_state
  );
endinterface

// File: rtl/axi4_lite_req_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master command port among NUM_REQ requesters.
// Define AXI4_LITE_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module axi4_lite_req_arbiter #(
  parameter int NUM_REQ = 4
) (
  input logic                   ACLK,
  input logic                   ARESETn,
  axi4_lite_req_arbiter_if.slave bus
);
  localparam int GW = $clog2(NUM_REQ);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  // Handshake: req_ready is a combinational pulse in IDLE while the chosen
  // req_valid is high; the command is taken on that same clock edge.
  logic [1:0]    r_state;
  logic [GW-1:0] r_grant;
  logic          r_write;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wstrb;
  logic [31:0]   r_rdata;
  logic [1:0]    r_resp;
`ifndef AXI4_LITE_ARB_FIXED_PRIO_EN
  logic [GW-1:0] r_rr_ptr;
`endif

  logic          w_any;
  logic          w_found;
  logic [GW-1:0] w_grant;
`ifndef AXI4_LITE_ARB_FIXED_PRIO_EN
  logic [GW:0]   w_sum;
  logic [GW-1:0] w_idx;
`endif

  always_comb begin
    w_any   = |bus.req_valid;
    w_found = 1'b0;
    w_grant = '0;
`ifndef AXI4_LITE_ARB_FIXED_PRIO_EN
    w_sum   = '0;
    w_idx   = '0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef AXI4_LITE_ARB_FIXED_PRIO_EN
      if (!w_found && bus.req_valid[i]) begin
        w_found = 1'b1;
        w_grant = GW'(i);
      end
`else
      // Search upward from the pointer, wrapping modulo NUM_REQ.
      w_sum = {1'b0, r_rr_ptr} + (GW+1)'(i);
      if (w_sum >= (GW+1)'(NUM_REQ)) w_sum = w_sum - (GW+1)'(NUM_REQ);
      w_idx = w_sum[GW-1:0];
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
`endif
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (ARESETn && (r_state == IDLE) && w_any) bus.req_ready[w_grant] = 1'b1;
  end

  always_comb begin
    bus.rsp_valid = '0;
    if (r_state == RESP) bus.rsp_valid[r_grant] = 1'b1;
  end

  assign bus.m_write_en = (r_state == ISSUE) &&  r_write;
  assign bus.m_read_en  = (r_state == ISSUE) && !r_write;
  assign bus.m_addr     = r_addr;
  assign bus.m_wdata    = r_wdata;
  assign bus.m_wstrb    = r_wstrb;
  assign bus.rsp_rdata  = r_rdata;
  assign bus.rsp_resp   = r_resp;
  assign bus.busy       = (r_state != IDLE);
  assign bus.dbg_state  = r_state;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_rdata  <= '0;
      r_resp   <= '0;
`ifndef AXI4_LITE_ARB_FIXED_PRIO_EN
      r_rr_ptr <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant <= w_grant;
            r_write <= bus.req_write[w_grant];
            r_addr  <= bus.req_addr[32*w_grant +: 32];
            r_wdata <= bus.req_wdata[32*w_grant +: 32];
            r_wstrb <= bus.req_wstrb[4*w_grant +: 4];
            r_state <= ISSUE;
          end
        end
        ISSUE: r_state <= WAIT;
        WAIT: begin
          // Only the done pulse matching the latched direction ends the wait.
          if (r_write && bus.m_write_done) begin
            r_rdata <= '0;
            r_resp  <= bus.m_write_resp;
            r_state <= RESP;
          end else if (!r_write && bus.m_read_done) begin
            r_rdata <= bus.m_read_data;
            r_resp  <= bus.m_read_resp;
            r_state <= RESP;
          end
        end
        RESP: begin
`ifndef AXI4_LITE_ARB_FIXED_PRIO_EN
          r_rr_ptr <= (r_grant == GW'(NUM_REQ-1)) ? '0 : r_grant + 1'b1;
`endif
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/axi4_lite_req_arbiter.md
Name: axi4_lite_req_arbiter

Overview:
- Shares one axi4_lite_master user-side command port between NUM_REQ independent requesters, e.g. CPU, DMA and debug.
- Grants one requester at a time using round-robin arbitration.
- Latches the granted command and holds it stable to the master for the whole transaction.
- Issues a one-cycle write/read enable, waits for the master's done pulse, then routes data and response back to the granted requester.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
GW, $clog2(NUM_REQ), grant index width (derived; do not override)

Ports:
ACLK  input  1  clock
ARESETn  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester command pending
req_write  input  NUM_REQ  1=write, 0=read
req_addr  input  NUM_REQ*32  packed addresses, requester i at [32i+:32]
req_wdata  input  NUM_REQ*32  packed write data
req_wstrb  input  NUM_REQ*4  packed write strobes
req_ready  output  NUM_REQ  one-cycle accept pulse to granted requester
rsp_valid  output  NUM_REQ  one-cycle completion pulse to granted requester
rsp_rdata  output  32  read data (shared, qualified by rsp_valid)
rsp_resp  output  2  BRESP/RRESP of completed transfer
m_write_en  output  1  to master write_en
m_read_en  output  1  to master read_en
m_addr  output  32  to master write_addr_in and read_addr_in
m_wdata  output  32  to master write_data_in
m_wstrb  output  4  to master strobe_in
m_read_data  input  32  from master read_data_out
m_write_resp  input  2  from master write_response_out
m_read_resp  input  2  from master read_response_out
m_write_done  input  1  from master write_done
m_read_done  input  1  from master read_done
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock ACLK; reset ARESETn is asynchronous, active-low.
- Reset values: all outputs 0, state=IDLE, rr_ptr=0.
- States are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid: grant = first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - In the same cycle: pulse req_ready[grant] and latch write flag, addr, wdata and wstrb into registers. Go to ISSUE.
  - If no req_valid: stay in IDLE.
- ISSUE:
  - Assert exactly one of m_write_en or m_read_en for exactly 1 cycle. Go to WAIT.
- WAIT:
  - Write: wait for m_write_done. Read: wait for m_read_done.
  - On the matching done: capture m_read_data (reads only; otherwise rsp_rdata=0) and the matching resp. Go to RESP.
  - A done pulse of the non-matching type is ignored.
  - No timeout; the block waits indefinitely.
- RESP:
  - rsp_valid[grant]=1 for 1 cycle, with rsp_rdata/rsp_resp valid in that same cycle.
  - rr_ptr <= (grant+1) mod NUM_REQ. Return to IDLE.
- Master-facing outputs:
  - m_addr/m_wdata/m_wstrb are driven only from the latched registers.
  - They are stable from ISSUE through RESP and change only at the next grant.
- Throughput:
  - The earliest new grant is the cycle after RESP.
  - Back-to-back transfers from different requesters must not overlap.
  - Exactly one outstanding transfer at any time.
- Requester protocol:
  - A requester holds req_valid and its command until it sees req_ready.
  - Deassertion before req_ready is legal; the command is simply not taken.
- Simultaneous requests: round-robin guarantees each of K continuously requesting sources is served within K grants.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Reset mid-transfer: return to IDLE immediately and drop the transfer. No rsp_valid is generated; the master is reset by the same ARESETn.
- req_ready and rsp_valid are one-hot or zero at all times.

Optional Feature:
- Macro: AXI4_LITE_ARB_FIXED_PRIO_EN.
- Defined: rr_ptr is removed and the lowest-index asserted req_valid always wins. Requester 0 has highest priority; starvation of higher indices is permitted.
- Undefined (default): round-robin as specified above.

Test Plan:
- Single write: req 2 write addr 0x0000_0010 data 0xDEADBEEF strb 0xF, slave BRESP=00.
  - Expect req_ready[2] pulse, one m_write_en cycle, m_addr=0x10.
  - Expect rsp_valid[2] with rsp_resp=00 one cycle after write_done.
- Single read: req 1 read 0x0000_0020, slave returns 0x12345678 RRESP=00.
  - Expect rsp_valid[1], rsp_rdata=0x12345678, rsp_resp=00.
- Round-robin fairness: req 0..3 all held valid for 8 transfers from reset.
  - Grant order 0,1,2,3,0,1,2,3.
  - Under AXI4_LITE_ARB_FIXED_PRIO_EN: 0,0,0,... while req 0 stays valid.
- Wrap and skip: rr_ptr=3, only req 1 valid -> grant 1, then rr_ptr=2.
- Error response: slave returns BRESP=10 on write from req 3.
  - Expect rsp_resp=10 at rsp_valid[3].
  - Expect m_addr/m_wdata unchanged from ISSUE to RESP.
- Reset in WAIT: drop ARESETn during a read.
  - Expect all outputs 0 and no rsp_valid.
  - After release, a new request from req 0 is granted first.
